fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Multicycle sequencer and PC owner for the core. Drives the 3-bit state and the
//  32-bit pc into the instruction memory, and latches the returned instruction into
//  the instruction register (IR). Advances FETCH->DECODE->EXECUTE->[MEM]->WRITEBACK
//  and selects the next PC. Downstream decode/ALU/LSU stages consume ir and state.
// PARAMETERS
//  RESET_PC   32'h0000_0000  pc value loaded on reset
//  MEM_TMO    16             cycles in MEM without mem_ready before mem_timeout fires
// PORTS
//  clk           in   1   system clock, all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  instr_in      in   32  instruction word from imem, valid while state==FETCH
//  pc_target     in   32  branch/jump target from execute, sampled in WRITEBACK
//  pc_sel        in   1   1 = take pc_target in WRITEBACK, 0 = pc+4
//  mem_ready     in   1   LSU completion handshake, sampled only in MEM
//  state         out  3   current sequencer state (encoding below)
//  pc            out  32  address of the current instruction
//  ir            out  32  latched instruction word
//  retired       out  32  count of completed instructions
//  misaligned    out  1   sticky: a taken target had pc_target[1:0]!=0
//  mem_timeout   out  1   sticky: MEM exceeded MEM_TMO cycles
//  halted        out  1   1 while in HALT
// BEHAVIOUR
//  - Encoding: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WRITEBACK=5 HALT=6; 7 is illegal.
//  - Reset values: state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), retired=0,
//    misaligned=0, mem_timeout=0, halted=0. rst wins over every other event.
//  - IDLE -> FETCH on the first edge after rst deasserts.
//  - FETCH: exactly 1 cycle; ir<=instr_in on the edge that leaves FETCH; next DECODE.
//  - DECODE: 1 cycle. If ir[6:0]==7'b1110011 (SYSTEM), go to HALT; else go to EXECUTE.
//  - EXECUTE: 1 cycle. If opcode is LOAD (0000011) or STORE (0100011), go to MEM;
//    else go to WRITEBACK.
//  - MEM: hold while !mem_ready; 16-bit wait counter cleared on entry.
//    * mem_ready=1: go to WRITEBACK next edge.
//    * Counter reaches MEM_TMO-1 without ready: set mem_timeout and go to HALT.
//    * mem_ready outside MEM is ignored.
//  - WRITEBACK: 1 cycle; pc <= pc_sel ? {pc_target[31:2],2'b00} : pc+32'd4
//    (mod 2^32, so 0xFFFF_FFFC wraps to 0). retired += 1 (wraps). Next state FETCH.
//    If pc_sel && pc_target[1:0]!=0, set misaligned; pc still updates, low bits cleared.
//  - HALT: absorbing; pc, ir and retired frozen; halted=1; only rst leaves.
//  - Illegal state 7: go to HALT next edge.
//  - pc changes only in WRITEBACK and on reset, so it is stable through FETCH.
//  - Latency: 4 cycles per non-memory instruction; 5+wait cycles per load/store.
//  - Reset asserted mid-instruction discards the in-flight instruction; retired is
//    not incremented.
// STRUCTURE
//  - Shared package core_pkg: state encodings (ST_IDLE..ST_HALT), opcode constants
//    (OP_LOAD, OP_STORE, OP_SYSTEM), NOP word.
//  - One sub-module, pc_next: combinational next-PC plus misalignment detection.
//    Sequencer FSM, IR, counters and sticky flags stay in fetch_ctrl.
// TESTING
//  1. Reset, then 3 ADDI words at 0x0/0x4/0x8 -> states 0,1,2,3,5,1,...; pc 0->4->8;
//     retired=3 after 12 cycles past IDLE.
//  2. LW with mem_ready low for 3 cycles -> MEM held for 4 cycles, then WRITEBACK,
//     pc+=4, retired+=1.
//  3. pc_sel=1, pc_target=0x100 in WRITEBACK -> next FETCH pc=0x100;
//     pc_target=0x102 -> pc=0x100, misaligned=1 (stays 1).
//  4. pc=0xFFFF_FFFC, pc_sel=0 -> pc wraps to 0x0; ECALL (0x00000073) -> HALT, halted=1;
//     pc, ir, retired frozen for 20 cycles.
//  5. STORE with mem_ready never asserted -> mem_timeout=1 and HALT after MEM_TMO
//     cycles in MEM.
//  6. rst pulsed during MEM and during EXECUTE -> all outputs return to reset values;
//     FETCH resumes at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared sequencer definitions: state encodings, the opcodes the sequencer
// branches on, and the NOP word the IR resets to.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the sequencer (master) and the imem/execute/LSU side (slave).
// mem_ready is a level completion strobe that is only looked at while state==ST_MEM.
interface fetch_ctrl_if;
  import core_pkg::*;

  logic [31:0] instr_in;
  logic [31:0] pc_target;
  logic        pc_sel;
  logic        mem_ready;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] retired;
  logic        misaligned;
  logic        mem_timeout;
  logic        halted;

  modport master (
    input  instr_in, pc_target, pc_sel, mem_ready,
    output state, pc, ir, retired, misaligned, mem_timeout, halted
  );

  modport slave (
    output instr_in, pc_target, pc_sel, mem_ready,
    input  state, pc, ir, retired, misaligned, mem_timeout, halted
  );

endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Next-PC selection for WRITEBACK: word-aligned branch target or pc+4,
// plus a flag for a taken target with nonzero low bits.
module pc_next (
  input  logic [31:0] pc,
  input  logic [31:0] pc_target,
  input  logic        pc_sel,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc  = pc_sel ? {pc_target[31:2], 2'b00} : pc + 32'd4;
    misalign = pc_sel && (pc_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Multicycle sequencer and PC owner: walks FETCH/DECODE/EXECUTE/[MEM]/WRITEBACK,
// latches the IR, counts retired instructions and keeps the sticky fault flags.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_TMO  = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam logic [15:0] TMO_LAST = 16'(MEM_TMO - 1);

  logic [15:0] wait_cnt;
  logic [31:0] next_pc;
  logic        misalign;
  logic [6:0]  opcode;

  assign opcode = bus.ir[6:0];

  pc_next u_pc_next (
    .pc        (bus.pc),
    .pc_target (bus.pc_target),
    .pc_sel    (bus.pc_sel),
    .next_pc   (next_pc),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.state       <= ST_IDLE;
      bus.pc          <= RESET_PC;
      bus.ir          <= NOP_WORD;
      bus.retired     <= 32'd0;
      bus.misaligned  <= 1'b0;
      bus.mem_timeout <= 1'b0;
      bus.halted      <= 1'b0;
      wait_cnt        <= 16'd0;
    end else begin
      case (bus.state)
        ST_IDLE: bus.state <= ST_FETCH;
        ST_FETCH: begin
          bus.ir    <= bus.instr_in;
          bus.state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (opcode == OP_SYSTEM) begin
            bus.state  <= ST_HALT;
            bus.halted <= 1'b1;
          end else begin
            bus.state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (opcode == OP_LOAD || opcode == OP_STORE) begin
            bus.state <= ST_MEM;
            wait_cnt  <= 16'd0;
          end else begin
            bus.state <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          // A completion on the last allowed cycle still wins over the timeout.
          if (bus.mem_ready) begin
            bus.state <= ST_WRITEBACK;
          end else if (wait_cnt == TMO_LAST) begin
            bus.mem_timeout <= 1'b1;
            bus.halted      <= 1'b1;
            bus.state       <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_WRITEBACK: begin
          bus.pc      <= next_pc;
          bus.retired <= bus.retired + 32'd1;
          if (misalign) bus.misaligned <= 1'b1;
          bus.state   <= ST_FETCH;
        end
        ST_HALT: bus.halted <= 1'b1;
        default: begin
          bus.state  <= ST_HALT;
          bus.halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
